// File: rtl/ppu_sparse_compressor_if.sv
// Handshake bundle for ppu_sparse_compressor: dense beat input, (value, index) entry output
// and the per-channel entry-count report.
interface ppu_sparse_compressor_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned MAX_K  = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned K_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic [K_W-1:0]          in_k;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_value;
  logic [IDX_W-1:0]        out_index;
  logic [K_W-1:0]          out_k;
  logic                    cnt_valid;
  logic [K_W-1:0]          cnt_k;
  logic [CNT_W-1:0]        cnt_num;
  logic                    err_ovf;

  // Upstream/downstream environment side
  modport master (
    output in_valid, in_data, in_k, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_k,
    input  cnt_valid, cnt_k, cnt_num, err_ovf
  );

  // Compressor side
  modport slave (
    input  in_valid, in_data, in_k, in_last, out_ready,
    output in_ready, out_valid, out_value, out_index, out_k,
    output cnt_valid, cnt_k, cnt_num, err_ovf
  );
endinterface

// File: rtl/ppu_sparse_compressor.sv
// Serialises dense pooled beats into zero-run-length (value, index) entries and reports a
// per-channel entry count. Define PPU_RELU_EN to clamp negative elements to zero before compression.
module ppu_sparse_compressor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned MAX_K  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ppu_sparse_compressor_if.slave bus
);
  localparam int unsigned K_W   = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] MAX_RUN  = '1;
  localparam logic [CNT_W-1:0] MAX_CNT  = '1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [LANES*DATA_W-1:0] data_q;
  logic                    last_q;
  logic                    first_q;
  logic [K_W-1:0]          k_q;
  logic [PTR_W-1:0]        ptr;
  logic [IDX_W-1:0]        run;
  logic [CNT_W-1:0]        count;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_value_q;
  logic [IDX_W-1:0]        out_index_q;
  logic [K_W-1:0]          out_k_q;
  logic                    cnt_valid_q;
  logic [K_W-1:0]          cnt_k_q;
  logic [CNT_W-1:0]        cnt_num_q;
  logic                    err_ovf_q;

  // Lane selection with optional ReLU; out-of-range lanes read as zero
  function automatic logic [DATA_W-1:0] lane_elem(input logic [LANES*DATA_W-1:0] d,
                                                  input logic [PTR_W-1:0]        idx);
    logic [DATA_W-1:0] e;
    e = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (idx == PTR_W'(i)) e = d[i*DATA_W +: DATA_W];
    end
`ifdef PPU_RELU_EN
    if (e[DATA_W-1]) e = '0;
`endif
    return e;
  endfunction

  logic              advance;
  logic              last_lane;
  logic              ovf_hit;
  logic [IDX_W-1:0]  run_adv;
  logic [CNT_W-1:0]  count_adv;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [DATA_W-1:0] elem_nxt;
  logic [DATA_W-1:0] elem_first;

  // The presented entry (or a silent zero skip) retires when downstream is not stalling it
  assign advance    = (state == SCAN) && (!out_valid_q || bus.out_ready);
  assign last_lane  = (ptr == LAST_PTR);
  assign run_adv    = out_valid_q ? '0 : run + IDX_W'(1);
  assign ovf_hit    = out_valid_q && (count == MAX_CNT);
  assign count_adv  = (out_valid_q && (count != MAX_CNT)) ? count + CNT_W'(1) : count;
  assign ptr_nxt    = ptr + PTR_W'(1);
  assign elem_nxt   = lane_elem(data_q, ptr_nxt);
  assign elem_first = lane_elem(bus.in_data, PTR_W'(0));

  // Output registers carry the decision for the lane evaluated in the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      k_q         <= '0;
      ptr         <= '0;
      run         <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
      out_k_q     <= '0;
      cnt_valid_q <= 1'b0;
      cnt_k_q     <= '0;
      cnt_num_q   <= '0;
      err_ovf_q   <= 1'b0;
    end else begin
      cnt_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state       <= SCAN;
            in_ready_q  <= 1'b0;
            data_q      <= bus.in_data;
            last_q      <= bus.in_last;
            first_q     <= 1'b0;
            ptr         <= '0;
            out_valid_q <= (elem_first != '0) || (run == MAX_RUN);
            out_value_q <= elem_first;
            out_index_q <= run;
            if (first_q) begin
              k_q     <= bus.in_k;
              out_k_q <= bus.in_k;
            end else begin
              out_k_q <= k_q;
            end
          end
        end
        SCAN: begin
          if (advance) begin
            run   <= run_adv;
            count <= count_adv;
            ptr   <= ptr_nxt;
            if (ovf_hit) err_ovf_q <= 1'b1;
            if (last_lane) begin
              out_valid_q <= 1'b0;
              if (last_q) begin
                state       <= DONE;
                cnt_valid_q <= 1'b1;
                cnt_k_q     <= k_q;
                cnt_num_q   <= count_adv;
              end else begin
                state      <= IDLE;
                in_ready_q <= 1'b1;
              end
            end else begin
              out_valid_q <= (elem_nxt != '0) || (run_adv == MAX_RUN);
              out_value_q <= elem_nxt;
              out_index_q <= run_adv;
            end
          end
        end
        DONE: begin
          // Trailing zeros are dropped with the run; next beat opens a new channel
          state      <= IDLE;
          in_ready_q <= 1'b1;
          run        <= '0;
          count      <= '0;
          first_q    <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_index = out_index_q;
  assign bus.out_k     = out_k_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt_k     = cnt_k_q;
  assign bus.cnt_num   = cnt_num_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_ppu_sparse_compressor.sv
// Directed and randomized bench for ppu_sparse_compressor against a channel-level
// zero-run-length reference model.
module tb_ppu_sparse_compressor;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned MAX_K  = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned K_W    = $clog2(MAX_K);
  localparam int MAXRUN = (1 << IDX_W) - 1;
  localparam int MAXCNT = (1 << CNT_W) - 1;
`ifdef PPU_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    int value;
    int index;
    int k;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: manual_ready
  bit   manual_ready = 1'b1;
  int   last_acc = 0;

  ent_t got_q[$];
  int   got_cnt_k[$];
  int   got_cnt_num[$];
  int   got_cnt_cyc[$];
  int   exp_val[$];
  int   exp_idx[$];
  int   exp_num = 0;

  ppu_sparse_compressor_if #(
    .DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W), .MAX_K(MAX_K), .CNT_W(CNT_W)
  ) bus ();

  ppu_sparse_compressor #(
    .DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W), .MAX_K(MAX_K), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      bus.out_ready = 1'b1;
      else if (ready_mode == 1) bus.out_ready = ($urandom_range(99) < 60);
      else                      bus.out_ready = manual_ready;
    end
  end

  // Record accepted entries and count reports in the middle of each cycle
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got_q.push_back('{int'(signed'(bus.out_value)), int'(bus.out_index), int'(bus.out_k)});
    if (bus.cnt_valid === 1'b1) begin
      got_cnt_k.push_back(int'(bus.cnt_k));
      got_cnt_num.push_back(int'(bus.cnt_num));
      got_cnt_cyc.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: walk the whole channel's element list applying the run-length rules
  function automatic void build_expect(input int elems[$]);
    int run = 0;
    int n = 0;
    exp_val.delete();
    exp_idx.delete();
    foreach (elems[i]) begin
      int e = elems[i];
      if (RELU && e < 0) e = 0;
      if (e != 0) begin
        exp_val.push_back(e); exp_idx.push_back(run); run = 0; n++;
      end else if (run == MAXRUN) begin
        exp_val.push_back(0); exp_idx.push_back(run); run = 0; n++;
      end else begin
        run++;
      end
    end
    exp_num = (n > MAXCNT) ? MAXCNT : n;
  endfunction

  task automatic start_channel(input int elems[$]);
    @(posedge clk);
    #2;
    got_q.delete();
    got_cnt_k.delete();
    got_cnt_num.delete();
    got_cnt_cyc.delete();
    build_expect(elems);
  endtask

  task automatic send_beat(input logic [LANES*DATA_W-1:0] d, input int k, input bit last);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_k     = K_W'(k);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      guard++;
      if (guard > 500) break;
    end
    check("in_ready_seen", 32'(bus.in_ready), 32'(1));
    last_acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_channel(input int elems[$], input int k);
    int nb = elems.size() / LANES;
    for (int b = 0; b < nb; b++) begin
      logic [LANES*DATA_W-1:0] d;
      for (int l = 0; l < int'(LANES); l++) d[l*DATA_W +: DATA_W] = DATA_W'(elems[b*LANES + l]);
      // in_k on non-first beats is scrambled: it must be ignored
      send_beat(d, (b == 0) ? k : int'($urandom_range(MAX_K - 1)), b == nb - 1);
    end
  endtask

  task automatic finish_channel(input string tag, input int k, input int exp_cyc);
    int e0;
    for (int i = 0; i < 3000 && got_cnt_k.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    check($sformatf("%s_cnt_pulses", tag), 32'(got_cnt_k.size()), 32'(1));
    if (got_cnt_k.size() > 0) begin
      check($sformatf("%s_cnt_k", tag), 32'(got_cnt_k[0]), 32'(k));
      check($sformatf("%s_cnt_num", tag), 32'(got_cnt_num[0]), 32'(exp_num));
      if (exp_cyc >= 0) check($sformatf("%s_cnt_cycle", tag), 32'(got_cnt_cyc[0]), 32'(exp_cyc));
    end
    check($sformatf("%s_n_entries", tag), 32'(got_q.size()), 32'(exp_val.size()));
    for (int i = 0; i < exp_val.size() && i < got_q.size(); i++) begin
      e0 = n_err;
      check($sformatf("%s_value[%0d]", tag, i), 32'(got_q[i].value), 32'(exp_val[i]));
      check($sformatf("%s_index[%0d]", tag, i), 32'(got_q[i].index), 32'(exp_idx[i]));
      check($sformatf("%s_out_k[%0d]", tag, i), 32'(got_q[i].k), 32'(k));
      if (n_err != e0) break;
    end
  endtask

  task automatic run_channel(input string tag, input int elems[$], input int k, input int mode);
    ready_mode = mode;
    start_channel(elems);
    send_channel(elems, k);
    finish_channel(tag, k, (mode == 0) ? last_acc + int'(LANES) + 1 : -1);
  endtask

  initial begin
    int elems[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_k     = '0;
    bus.in_last  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_cnt_valid", 32'(bus.cnt_valid), 32'(0));
    check("rst_err_ovf", 32'(bus.err_ovf), 32'(0));
    check("rst_out_value", 32'(bus.out_value), 32'(0));
    check("rst_out_index", 32'(bus.out_index), 32'(0));
    check("rst_out_k", 32'(bus.out_k), 32'(0));
    check("rst_cnt_k", 32'(bus.cnt_k), 32'(0));
    check("rst_cnt_num", 32'(bus.cnt_num), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Basic single-beat channel
    elems = '{5, 0, 0, -3};
    run_channel("s1", elems, 2, 0);

    // Long zero runs across beats with a run-cap zero entry and dropped tail
    elems.delete();
    for (int i = 0; i < 20; i++) elems.push_back(0);
    elems.push_back(7); elems.push_back(0); elems.push_back(0); elems.push_back(0);
    run_channel("s2", elems, 5, 0);
    check("s2_num_const", 32'(got_cnt_num.size() > 0 ? got_cnt_num[0] : -1), 32'(2));

    // Downstream stall while the first entry is presented
    elems = '{5, 0, 0, -3};
    ready_mode = 2;
    manual_ready = 1'b0;
    start_channel(elems);
    send_channel(elems, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_stall_valid", 32'(bus.out_valid), 32'(1));
      check("s3_stall_value", 32'(signed'(bus.out_value)), 32'(5));
      check("s3_stall_index", 32'(bus.out_index), 32'(0));
      check("s3_stall_in_ready", 32'(bus.in_ready), 32'(0));
    end
    manual_ready = 1'b1;
    finish_channel("s3", 2, last_acc + int'(LANES) + 1 + 3);
    ready_mode = 0;

    // All-zero channel
    elems = '{0, 0, 0, 0};
    run_channel("s4", elems, 1, 0);

    // Reset in the middle of a scan
    elems = '{3, 4, 5, 6};
    start_channel(elems);
    send_channel(elems, 3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("s5_out_valid", 32'(bus.out_valid), 32'(0));
    check("s5_in_ready", 32'(bus.in_ready), 32'(1));
    check("s5_cnt_valid", 32'(bus.cnt_valid), 32'(0));
    check("s5_out_value", 32'(bus.out_value), 32'(0));
    check("s5_out_index", 32'(bus.out_index), 32'(0));
    check("s5_out_k", 32'(bus.out_k), 32'(0));
    check("s5_cnt_num", 32'(bus.cnt_num), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    elems = '{0, 9, 0, 0};
    run_channel("s5b", elems, 4, 0);

    // Negative elements (ReLU dependent)
    elems = '{-4, 6, 0, 0};
    run_channel("s6", elems, 6, 0);

    // Randomized channels with varying density and backpressure
    for (int c = 0; c < 24; c++) begin
      int nb = int'($urandom_range(1, 6));
      int zp = (c % 3 == 0) ? 30 : ((c % 3 == 1) ? 80 : 97);
      elems.delete();
      for (int i = 0; i < nb * int'(LANES); i++)
        elems.push_back(($urandom_range(99) < zp) ? 0 : int'($urandom_range(1000)) - 500);
      run_channel($sformatf("rnd%0d", c), elems, int'($urandom_range(MAX_K - 1)), c % 2);
    end
    check("no_ovf_yet", 32'(bus.err_ovf), 32'(0));

    // Count saturation: more nonzero entries than the counter holds
    elems.delete();
    for (int i = 0; i < 70 * int'(LANES); i++) elems.push_back(int'($urandom_range(1, 300)));
    run_channel("sat", elems, 7, 0);
    check("sat_err_ovf", 32'(bus.err_ovf), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
